// File: rtl/pulse_transmitter_sequencer_pkg.sv
// Shared definitions for the pulse transmitter sequencer: FSM state encoding and
// the layout of a symbol word {level, duration} read from symbol memory.
package pulse_transmitter_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        ARM   = 3'd3,
        RUN   = 3'd4
    } seq_state_t;

    // Duration occupies the low bits of a symbol word, the level bit sits directly above it.
    localparam int SYM_DUR_LSB = 0;

    function automatic int sym_level_bit(input int timer_width);
        return SYM_DUR_LSB + timer_width;
    endfunction

endpackage

// File: rtl/pulse_transmitter_sequencer.sv
// Plays a list of {level, duration} symbols from memory onto tx_out, pacing each
// symbol with an external countdown timer and prefetching the following symbol.
module pulse_transmitter_sequencer
    import pulse_transmitter_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH      = 6,
    parameter int TIMER_WIDTH     = 8,
    parameter int PRESCALER_WIDTH = 16,
    localparam int PW             = $clog2(PRESCALER_WIDTH)
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PW-1:0]          cfg_prescaler,
    input  logic [ADDR_WIDTH-1:0]  cfg_last_addr,
    input  logic [7:0]             cfg_loop_count,
    input  logic                   cfg_idle_level,
    output logic                   mem_rd,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [TIMER_WIDTH:0]   mem_data,
    output logic                   timer_en,
    output logic [PW-1:0]          timer_prescaler,
    output logic [TIMER_WIDTH-1:0] timer_duration,
    input  logic                   timer_request,
    input  logic                   timer_pulse,
    output logic                   tx_out,
    output logic                   busy,
    output logic                   done
);

    localparam int LEVEL_BIT = sym_level_bit(TIMER_WIDTH);

    seq_state_t             state;
    logic [PW-1:0]          presc_q;
    logic [ADDR_WIDTH-1:0]  last_addr_q;
    logic                   idle_q;
    logic [7:0]             loops_left;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   nxt_level;
    logic [TIMER_WIDTH-1:0] nxt_dur;
    logic                   nxt_valid;
    logic                   nxt_end;
    logic                   rd_pending;

    logic                   nv_level;
    logic [TIMER_WIDTH-1:0] nv_dur;
    logic                   at_last;
    logic                   has_next;
    logic [ADDR_WIDTH-1:0]  follow_addr;
    logic                   issue_next;

    // At the minimum symbol interval the prefetched word is still on mem_data when
    // it is needed, so bypass the next-symbol register until it has been captured.
    always_comb begin
        nv_level    = nxt_valid ? nxt_level : mem_data[LEVEL_BIT];
        nv_dur      = nxt_valid ? nxt_dur : mem_data[SYM_DUR_LSB +: TIMER_WIDTH];
        at_last     = (addr_q == last_addr_q);
        has_next    = !at_last || (loops_left != 8'd0);
        follow_addr = at_last ? '0 : addr_q + ADDR_WIDTH'(1);
        issue_next  = (state == LOAD) || ((state == RUN) && timer_pulse && !nxt_end);
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state           <= IDLE;
            presc_q         <= '0;
            last_addr_q     <= '0;
            idle_q          <= 1'b0;
            loops_left      <= '0;
            addr_q          <= '0;
            nxt_level       <= 1'b0;
            nxt_dur         <= '0;
            nxt_valid       <= 1'b0;
            nxt_end         <= 1'b0;
            rd_pending      <= 1'b0;
            mem_rd          <= 1'b0;
            mem_addr        <= '0;
            timer_en        <= 1'b0;
            timer_prescaler <= '0;
            timer_duration  <= '0;
            tx_out          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            done       <= 1'b0;
            rd_pending <= mem_rd;
            if (stop && (state != IDLE)) begin
                state     <= IDLE;
                timer_en  <= 1'b0;
                tx_out    <= idle_q;
                busy      <= 1'b0;
                nxt_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            presc_q     <= cfg_prescaler;
                            last_addr_q <= cfg_last_addr;
                            idle_q      <= cfg_idle_level;
                            loops_left  <= cfg_loop_count;
                            addr_q      <= '0;
                            mem_rd      <= 1'b1;
                            mem_addr    <= '0;
                            tx_out      <= cfg_idle_level;
                            busy        <= 1'b1;
                            nxt_valid   <= 1'b0;
                            nxt_end     <= 1'b0;
                            state       <= FETCH;
                        end
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        tx_out          <= mem_data[LEVEL_BIT];
                        timer_duration  <= mem_data[SYM_DUR_LSB +: TIMER_WIDTH];
                        timer_prescaler <= presc_q;
                        state           <= ARM;
                    end
                    ARM: begin
                        timer_en <= 1'b1;
                        state    <= RUN;
                    end
                    RUN: begin
                        if (rd_pending) begin
                            nxt_level <= mem_data[LEVEL_BIT];
                            nxt_dur   <= mem_data[SYM_DUR_LSB +: TIMER_WIDTH];
                            nxt_valid <= 1'b1;
                        end
                        if (timer_request && !nxt_end) begin
                            timer_duration <= nv_dur;
                        end
                        if (timer_pulse) begin
                            if (nxt_end) begin
                                tx_out   <= idle_q;
                                timer_en <= 1'b0;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                tx_out    <= nv_level;
                                nxt_valid <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase

                // One read per symbol: wrap to address 0 while repetitions remain, else mark END.
                if (issue_next) begin
                    mem_rd  <= has_next;
                    nxt_end <= !has_next;
                    if (has_next) begin
                        mem_addr <= follow_addr;
                        addr_q   <= follow_addr;
                        if (at_last) begin
                            loops_left <= loops_left - 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
// Directed bench for pulse_transmitter_sequencer with a behavioural symbol memory
// and countdown timer; each sequence is traced cycle by cycle and compared.
module tb_pulse_transmitter_sequencer;

    localparam int ADDR_WIDTH  = 6;
    localparam int TIMER_WIDTH = 8;
    localparam int PW          = 4;

    logic                   clk = 1'b0;
    logic                   sys_rst = 1'b1;
    logic                   start = 1'b0;
    logic                   stop = 1'b0;
    logic [PW-1:0]          cfg_prescaler = '0;
    logic [ADDR_WIDTH-1:0]  cfg_last_addr = '0;
    logic [7:0]             cfg_loop_count = '0;
    logic                   cfg_idle_level = 1'b0;
    logic                   mem_rd;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [TIMER_WIDTH:0]   mem_data = '0;
    logic                   timer_en;
    logic [PW-1:0]          timer_prescaler;
    logic [TIMER_WIDTH-1:0] timer_duration;
    logic                   timer_request = 1'b0;
    logic                   timer_pulse = 1'b0;
    logic                   tx_out;
    logic                   busy;
    logic                   done;

    pulse_transmitter_sequencer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .TIMER_WIDTH(TIMER_WIDTH),
        .PRESCALER_WIDTH(16)
    ) dut (
        .clk(clk),
        .sys_rst(sys_rst),
        .start(start),
        .stop(stop),
        .cfg_prescaler(cfg_prescaler),
        .cfg_last_addr(cfg_last_addr),
        .cfg_loop_count(cfg_loop_count),
        .cfg_idle_level(cfg_idle_level),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .timer_en(timer_en),
        .timer_prescaler(timer_prescaler),
        .timer_duration(timer_duration),
        .timer_request(timer_request),
        .timer_pulse(timer_pulse),
        .tx_out(tx_out),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [TIMER_WIDTH:0] memory [0:63];

    always @(posedge clk) begin
        if (mem_rd) mem_data <= memory[mem_addr];
    end

    // Timer: counts (duration+1) << prescaler enabled cycles to the first pulse, then
    // spends one reload cycle sampling the new duration before counting again.
    int   rem = 0;
    logic prev_en = 1'b0;
    logic reloading = 1'b0;

    always @(negedge clk) begin
        timer_pulse   = 1'b0;
        timer_request = 1'b0;
        if (!timer_en) begin
            prev_en   = 1'b0;
            reloading = 1'b0;
        end else begin
            if (!prev_en || reloading) rem = (int'(timer_duration) + 1) << timer_prescaler;
            if (reloading) begin
                reloading = 1'b0;
            end else begin
                rem = rem - 1;
                if (rem == 0) begin
                    timer_pulse   = 1'b1;
                    timer_request = 1'b1;
                    reloading     = 1'b1;
                end
            end
            prev_en = 1'b1;
        end
    end

    int compared = 0;
    int failed = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            failed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int presc, input int last, input int loops, input logic idle);
        cfg_prescaler  = PW'(presc);
        cfg_last_addr  = ADDR_WIDTH'(last);
        cfg_loop_count = 8'(loops);
        cfg_idle_level = idle;
    endtask

    logic        tx_hist [0:127];
    logic        en_hist [0:127];
    logic [63:0] trace;
    int          done_cycle, done_count, rd_count, rd_addr0_count, end_cycle;
    logic        end_en;

    // Pulses start now (just after a negedge) and records one sample per cycle until
    // busy falls plus a few idle cycles, or the cycle budget runs out.
    task automatic runTrace(input int max_cycles, input int extra_start_at, input int stop_at);
        done_cycle = 0; done_count = 0; rd_count = 0; rd_addr0_count = 0;
        end_cycle = 0; end_en = 1'b0; trace = '0;
        start = 1'b1;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            tx_hist[c] = tx_out;
            en_hist[c] = timer_en;
            if (done) begin
                done_count++;
                if (done_cycle == 0) done_cycle = c;
            end
            if (mem_rd) begin
                rd_count++;
                if (mem_addr == '0) rd_addr0_count++;
            end
            if (!busy && end_cycle == 0) begin
                end_cycle = c;
                end_en    = timer_en;
            end
            if (c == 1) begin
                cfg_prescaler  = cfg_prescaler + 1'b1;
                cfg_last_addr  = cfg_last_addr + 1'b1;
                cfg_loop_count = cfg_loop_count + 8'd3;
                cfg_idle_level = ~cfg_idle_level;
            end
            if (c == extra_start_at) start = 1'b1;
            if (c == stop_at) stop = 1'b1;
            if (end_cycle != 0 && c >= end_cycle + 4) break;
        end
        for (int c = 1; c <= end_cycle; c++) trace = {trace[62:0], tx_hist[c]};
        checkOutput("sequence ended", 64'(end_cycle != 0), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) memory[i] = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset tx_out", 64'(tx_out), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset timer_en", 64'(timer_en), 64'd0);
        checkOutput("reset mem_rd", 64'(mem_rd), 64'd0);
        checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset timer_duration", 64'(timer_duration), 64'd0);
        checkOutput("reset timer_prescaler", 64'(timer_prescaler), 64'd0);
        sys_rst = 1'b0;
        @(negedge clk);

        // Three-symbol pattern, played once: 5 high, 7 low, 2 high.
        memory[0] = {1'b1, 8'd3};
        memory[1] = {1'b0, 8'd5};
        memory[2] = {1'b1, 8'd0};
        applyStimulus(0, 2, 0, 1'b0);
        runTrace(40, 0, 0);
        checkOutput("single pass trace", trace, 64'b00111110000000110);
        checkOutput("single pass done cycle", 64'(done_cycle), 64'd17);
        checkOutput("single pass busy fall", 64'(end_cycle), 64'd17);
        checkOutput("single pass done count", 64'(done_count), 64'd1);
        checkOutput("single pass reads", 64'(rd_count), 64'd3);

        // Same pattern with a start pulse during RUN, which must change nothing.
        applyStimulus(0, 2, 0, 1'b0);
        runTrace(40, 5, 0);
        checkOutput("start in RUN trace", trace, 64'b00111110000000110);
        checkOutput("start in RUN done count", 64'(done_count), 64'd1);
        checkOutput("start in RUN reads", 64'(rd_count), 64'd3);

        // Two extra loops: pattern three times back to back, wrapping to address 0 twice.
        applyStimulus(0, 2, 2, 1'b0);
        runTrace(60, 0, 0);
        checkOutput("loop trace", trace,
                    64'b00_11111000000011_11111000000011_11111000000011_0);
        checkOutput("loop done cycle", 64'(done_cycle), 64'd45);
        checkOutput("loop done count", 64'(done_count), 64'd1);
        checkOutput("loop reads", 64'(rd_count), 64'd9);
        checkOutput("loop reads of addr 0", 64'(rd_addr0_count), 64'd3);

        // Single symbol with prescaler 2: high for (1+1)*4+1 = 9 cycles.
        memory[0] = {1'b1, 8'd1};
        applyStimulus(2, 0, 0, 1'b0);
        runTrace(40, 0, 0);
        checkOutput("prescaled trace", trace, 64'b001111111110);
        checkOutput("prescaled done cycle", 64'(done_cycle), 64'd12);
        checkOutput("prescaled busy fall", 64'(end_cycle), 64'd12);
        checkOutput("prescaled reads", 64'(rd_count), 64'd1);

        // Abort three cycles into RUN with idle level 1.
        memory[0] = {1'b0, 8'd9};
        memory[1] = {1'b1, 8'd2};
        applyStimulus(0, 1, 0, 1'b1);
        runTrace(30, 0, 6);
        checkOutput("stop trace", trace, 64'b1100001);
        checkOutput("stop busy fall", 64'(end_cycle), 64'd7);
        checkOutput("stop timer_en before", 64'(en_hist[6]), 64'd1);
        checkOutput("stop timer_en after", 64'(end_en), 64'd0);
        checkOutput("stop done count", 64'(done_count), 64'd0);

        // start together with stop in IDLE is ignored.
        applyStimulus(0, 1, 0, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        checkOutput("start+stop busy", 64'(busy), 64'd0);
        checkOutput("start+stop mem_rd", 64'(mem_rd), 64'd0);
        checkOutput("start+stop tx_out", 64'(tx_out), 64'd1);
        @(negedge clk);
        checkOutput("start+stop still idle", 64'(busy), 64'd0);

        // Reset during RUN with idle level 1: everything back to reset values, no done.
        applyStimulus(1, 1, 0, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("pre-reset busy", 64'(busy), 64'd1);
        checkOutput("pre-reset timer_en", 64'(timer_en), 64'd1);
        sys_rst = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        checkOutput("mid-run reset tx_out", 64'(tx_out), 64'd0);
        checkOutput("mid-run reset busy", 64'(busy), 64'd0);
        checkOutput("mid-run reset done", 64'(done), 64'd0);
        checkOutput("mid-run reset timer_en", 64'(timer_en), 64'd0);
        checkOutput("mid-run reset mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("mid-run reset timer_duration", 64'(timer_duration), 64'd0);
        checkOutput("mid-run reset timer_prescaler", 64'(timer_prescaler), 64'd0);
        @(negedge clk);
        checkOutput("after reset done", 64'(done), 64'd0);
        checkOutput("after reset busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
